// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: one fixed-latency
// access per grant, round-robin or M0-priority, with an M1 write-protect window.
module dm_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter bit          RR_EN  = 1'b1,
   parameter logic [ADDR_W-1:0] M1_WP_LIMIT = '0
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_cs,
   output logic              ram_rd,
   output logic              ram_oe,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned AW1 = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic              last_owner_q, last_owner_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;

   logic              cs_d, rd_d, busy_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_d;
   logic              m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
   logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;

   logic              win_c;
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              wp_hit_c;
   logic [DATA_W-1:0] cap_c;

   // Winner selection and payload mux; addr+1 <= limit avoids a constant compare when limit is 0
   always_comb begin
      win_c       = 1'b0;
      if (m0_req && m1_req) win_c = RR_EN ? ~last_owner_q : 1'b0;
      else                  win_c = m1_req;
      sel_we_c    = win_c ? m1_we    : m0_we;
      sel_addr_c  = win_c ? m1_addr  : m0_addr;
      sel_wdata_c = win_c ? m1_wdata : m0_wdata;
      wp_hit_c    = ({1'b0, sel_addr_c} + AW1'(1)) <= {1'b0, M1_WP_LIMIT};
      cap_c       = (!we_q && !err_q) ? ram_rdata : '0;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      cs_d         = 1'b0;
      rd_d         = 1'b0;
      ram_addr_d   = '0;
      ram_wdata_d  = '0;
      m0_ack_d     = 1'b0;
      m0_err_d     = 1'b0;
      m0_rdata_d   = '0;
      m1_ack_d     = 1'b0;
      m1_err_d     = 1'b0;
      m1_rdata_d   = '0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               owner_d     = win_c;
               we_d        = sel_we_c;
               addr_d      = sel_addr_c;
               wdata_d     = sel_wdata_c;
               err_d       = win_c & sel_we_c & wp_hit_c;
               cs_d        = ~err_d;
               rd_d        = ~sel_we_c;
               ram_addr_d  = sel_addr_c;
               ram_wdata_d = sel_wdata_c;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            state_d = DONE;
            if (owner_q) begin
               m1_ack_d   = 1'b1;
               m1_err_d   = err_q;
               m1_rdata_d = cap_c;
            end else begin
               m0_ack_d   = 1'b1;
               m0_err_d   = err_q;
               m0_rdata_d = cap_c;
            end
         end
         DONE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         ram_cs       <= 1'b0;
         ram_rd       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         m0_ack       <= 1'b0;
         m0_err       <= 1'b0;
         m0_rdata     <= '0;
         m1_ack       <= 1'b0;
         m1_err       <= 1'b0;
         m1_rdata     <= '0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         ram_cs       <= cs_d;
         ram_rd       <= rd_d;
         ram_addr     <= ram_addr_d;
         ram_wdata    <= ram_wdata_d;
         m0_ack       <= m0_ack_d;
         m0_err       <= m0_err_d;
         m0_rdata     <= m0_rdata_d;
         m1_ack       <= m1_ack_d;
         m1_err       <= m1_err_d;
         m1_rdata     <= m1_rdata_d;
         busy         <= busy_d;
      end
   end

   assign ram_oe = ram_rd;
   assign owner  = owner_q;

endmodule
